// File: rtl/move_sequencer.sv
// Multi-axis move sequencer: queues move commands and steps one profile generator per axis.
// Optional SEQ_ABORT_EN adds an abort input that flushes the queue and re-arms the generators.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the head on exit
// LOAD   | head entry visible on gen_*, gen_reset pulsed on all axes
// ARM    | gen_start raised on axes with nonzero steps; fin not sampled
// RUN    | holding gen_start until every active axis reports fin
// DONE   | move_done pulse, back to IDLE
module move_sequencer #(
    parameter int AXES  = 3,
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AXES*W-1:0]        cmd_steps,
    input  logic [AXES-1:0]          cmd_dir,
    input  logic [W-1:0]             cmd_f_max,
    input  logic [W-1:0]             cmd_f_min,
    input  logic [W-1:0]             cmd_delta,
    output logic [AXES-1:0]          gen_reset,
    output logic [AXES-1:0]          gen_start,
    output logic [AXES*W-1:0]        gen_steps,
    output logic [AXES-1:0]          gen_dir,
    output logic [W-1:0]             gen_f_max,
    output logic [W-1:0]             gen_f_min,
    output logic [W-1:0]             gen_delta,
    input  logic [AXES-1:0]          gen_fin,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     move_done
`ifdef SEQ_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = AXES*W + AXES + 3*W;
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [EW-1:0]     r_fifo [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AXES*W-1:0] r_steps;
    logic [AXES-1:0]   r_dir;
    logic [W-1:0]      r_f_max, r_f_min, r_delta;
    logic [AXES-1:0]   w_act;
    logic [AXES-1:0]   w_gen_reset_st;
    logic              w_abort, w_abort_rst;
    logic              w_push, w_pop;

`ifdef SEQ_ABORT_EN
    logic r_abort_rst;
    assign w_abort = abort;
    // the re-arm pulse lands in the cycle after abort, when the state is already IDLE
    always_ff @(posedge clk) begin
        if (reset) r_abort_rst <= 1'b0;
        else       r_abort_rst <= abort;
    end
    assign w_abort_rst = r_abort_rst;
`else
    assign w_abort     = 1'b0;
    assign w_abort_rst = 1'b0;
`endif

    assign cmd_ready = (r_count != C_FULL) && !w_abort;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !w_abort;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {cmd_steps, cmd_dir, cmd_f_max, cmd_f_min, cmd_delta};
    end

    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // head entry is latched on the pop edge so it is already valid during LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steps <= '0;
            r_dir   <= '0;
            r_f_max <= '0;
            r_f_min <= '0;
            r_delta <= '0;
        end else if (w_pop) begin
            {r_steps, r_dir, r_f_max, r_f_min, r_delta} <= r_fifo[r_rd_ptr];
        end
    end

    always_comb begin
        w_act = '0;
        for (int i = 0; i < AXES; i++) w_act[i] = |r_steps[i*W +: W];
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_gen_reset_st = '0;
        gen_start      = '0;
        move_done      = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0) w_next = S_LOAD;
            S_LOAD: begin
                w_gen_reset_st = '1;
                w_next         = S_ARM;
            end
            S_ARM: begin
                gen_start = w_act;
                w_next    = (w_act == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                gen_start = w_act;
                if (&(gen_fin | ~w_act)) w_next = S_DONE;
            end
            S_DONE: begin
                move_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next         = S_IDLE;
            w_gen_reset_st = '0;
            gen_start      = '0;
            move_done      = 1'b0;
        end
    end

    assign gen_reset   = w_gen_reset_st | {AXES{w_abort_rst}};
    assign gen_steps   = r_steps;
    assign gen_dir     = r_dir;
    assign gen_f_max   = r_f_max;
    assign gen_f_min   = r_f_min;
    assign gen_delta   = r_delta;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);
    assign queue_count = r_count;

endmodule
